// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam int MEM_LAT_MIN    = 1;
    localparam int MEM_LAT_MAX    = 4;
    localparam int STARVE_MAX_MIN = 1;
    localparam int STARVE_MAX_MAX = 15;

    // Counter widths sized for the largest legal parameter values.
    localparam int LAT_CNT_W = $clog2(MEM_LAT_MAX);
    localparam int STARVE_W  = $clog2(STARVE_MAX_MAX + 1);

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive fetch denials caused by data wins; raises force_if
// once the count reaches STARVE_MAX so fetch takes the next window.
module mem_arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic force_if
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;

    // dm_gnt only occurs inside an arbitration window.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (dm_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_if = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and data requesters,
// data first with a starvation guard, one transaction outstanding at a time.
//
//   state | meaning
//   IDLE  | nothing outstanding, arbitration window open
//   WAIT  | response pending; window reopens when lat_cnt == MEM_LAT-1
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       dm_wait_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LAT - 1);

    state_t                 state_q, state_d;
    owner_t                 owner_q, owner_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic                   resp;
    logic                   window;
    logic                   force_if;

    assign resp   = (state_q == WAIT) && (lat_cnt_q == LAT_LAST);
    assign window = (state_q == IDLE) || resp;
    assign busy   = (state_q == WAIT);

    mem_arb_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_guard (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .dm_gnt   (dm_gnt),
        .force_if (force_if)
    );

    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;

        if (window) begin
            if (force_if && if_req) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end

            lat_cnt_d = '0;
            if (if_gnt) begin
                mem_en  = 1'b1;
                mem_addr = if_addr;
                owner_d = OWN_IF;
                state_d = WAIT;
            end else if (dm_gnt) begin
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
                owner_d   = OWN_DM;
                state_d   = WAIT;
            end else begin
                state_d = IDLE;
            end
        end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
        end
    end

    // Response routing depends only on registered owner, never on new grants.
    assign if_rvalid = resp && (owner_q == OWN_IF);
    assign dm_rvalid = resp && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            lat_cnt_q   <= '0;
            if_wait_cnt <= '0;
            dm_wait_cnt <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            if (if_req && !if_gnt) begin
                if_wait_cnt <= if_wait_cnt + 32'd1;
            end
            if (dm_req && !dm_gnt) begin
                dm_wait_cnt <= dm_wait_cnt + 32'd1;
            end
        end
    end

endmodule
